// File: rtl/slot_alloc_select.sv
// Free-slot pool: grants up to ALLOC_WIDTH lowest-index free slots per cycle
// from a registered bitmap, accepts bulk releases, and publishes registered counts.
module slot_alloc_select #(
    parameter  int NUM_SLOTS   = 32,
    parameter  int ALLOC_WIDTH = 3,
    localparam int CW          = $clog2(ALLOC_WIDTH + 1),
    localparam int IW          = $clog2(NUM_SLOTS),
    localparam int FW          = $clog2(NUM_SLOTS + 1)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic [CW-1:0]                   alloc_req_count,
    output logic                            alloc_grant,
    output logic [NUM_SLOTS-1:0]            alloc_grant_mask,
    output logic [ALLOC_WIDTH-1:0][IW-1:0]  alloc_idx,
    output logic [ALLOC_WIDTH-1:0]          alloc_idx_valid,
    input  logic [NUM_SLOTS-1:0]            free_mask,
    output logic [FW-1:0]                   free_count,
    output logic [CW-1:0]                   alloc_avail,
    output logic                            err_double_free
);

    logic [NUM_SLOTS-1:0] free_bitmap;
    logic [NUM_SLOTS-1:0] free_next;
    logic [FW-1:0]        count_next;
    logic [CW-1:0]        avail_next;

    // Grant decision and lane selection. Each lane takes the lowest free slot
    // still left after the lower lanes have taken theirs.
    always_comb begin
        logic [NUM_SLOTS-1:0] remaining;
        logic [IW-1:0]        sel;
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        remaining        = free_bitmap;
        sel              = '0;
        alloc_grant_mask = '0;
        alloc_idx        = '0;
        alloc_idx_valid  = '0;
        alloc_grant      = (alloc_req_count != '0)
                        && (int'(alloc_req_count) <= ALLOC_WIDTH)
                        && (int'(alloc_req_count) <= int'(free_count));
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            if (alloc_grant && (k < int'(alloc_req_count))) begin
                sel = '0;
                for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                    if (remaining[i]) sel = IW'(i);
                end
                alloc_idx[k]          = sel;
                alloc_idx_valid[k]    = 1'b1;
                alloc_grant_mask[sel] = 1'b1;
                remaining[sel]        = 1'b0;
            end
        end
    end

    // A slot granted and released in the same cycle stays busy: the grant wins.
    always_comb begin
        if (flush) begin
            free_next = '1;
        end else begin
            free_next = (free_bitmap | free_mask) & ~alloc_grant_mask;
        end
        count_next = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_next = count_next + FW'(free_next[i]);
        end
        if (int'(count_next) < ALLOC_WIDTH) begin
            avail_next = CW'(count_next);
        end else begin
            avail_next = CW'(ALLOC_WIDTH);
        end
    end

    // Counts are registered from the same next-state value as the bitmap, so
    // they never disagree with it.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            free_bitmap     <= '1;
            free_count      <= FW'(NUM_SLOTS);
            alloc_avail     <= CW'(ALLOC_WIDTH);
            err_double_free <= 1'b0;
        end else begin
            free_bitmap <= free_next;
            free_count  <= count_next;
            alloc_avail <= avail_next;
            if (!flush && ((free_mask & free_bitmap) != '0)) begin
                err_double_free <= 1'b1;
            end
        end
    end

endmodule
